// File: rtl/axis_rp_arbiter_pkg.sv
// Shared types and helpers for the reconfigurable-partition stream arbiter.
//   state_t    : arbiter FSM states
//   DATA_W_DEF : default stream width of the partition TXD/RXD pair
//   rr_pick    : round-robin search for the next requester after a pointer
package axis_rp_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DATA_W_DEF = 512;
    localparam int unsigned MAX_REQ    = 8;

    // First set bit of req searching from ptr+1 with wrap-around over num entries.
    // Returns ptr when no bit is set; callers only use the result when req != 0.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int unsigned        num);
        logic [2:0] pick;
        logic       found;
        logic [3:0] sum;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= int'(MAX_REQ); i++) begin
            // ptr < num and i <= num, so one subtraction is enough to wrap
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= 4'(num)) begin
                sum = sum - 4'(num);
            end
            if (i <= int'(num) && !found && req[sum[2:0]]) begin
                pick  = sum[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_rp_arbiter_if.sv
// Stream bundle between the requesters, the arbiter and the partition.
//   s_*      : requester forward streams (NUM_REQ lanes, slice i = requester i)
//   m_*      : forward stream to partition TXD
//   r_*      : return stream from partition RXD
//   o_*      : return stream to requesters (data/last broadcast, valid one-hot)
// Modports: master = arbiter view, slave = environment view.
interface axis_rp_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 512
);
    logic [NUM_REQ*DATA_W-1:0] s_tdata;
    logic [NUM_REQ-1:0]        s_tlast;
    logic [NUM_REQ-1:0]        s_tvalid;
    logic [NUM_REQ-1:0]        s_tready;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic                      m_tvalid;
    logic                      m_tready;
    logic [DATA_W-1:0]         r_tdata;
    logic                      r_tlast;
    logic                      r_tvalid;
    logic                      r_tready;
    logic [DATA_W-1:0]         o_tdata;
    logic                      o_tlast;
    logic [NUM_REQ-1:0]        o_tvalid;
    logic [NUM_REQ-1:0]        o_tready;

    modport master (
        input  s_tdata, s_tlast, s_tvalid, m_tready, r_tdata, r_tlast, r_tvalid, o_tready,
        output s_tready, m_tdata, m_tlast, m_tvalid, r_tready, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        output s_tdata, s_tlast, s_tvalid, m_tready, r_tdata, r_tlast, r_tvalid, o_tready,
        input  s_tready, m_tdata, m_tlast, m_tvalid, r_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/axis_rp_id_fifo.sv
// In-order FIFO of granted requester IDs; the head names the owner of the
// next return packet.
//   clk, rst_n     : clock, async active-low reset
//   push, push_id  : enqueue an ID (accepted when not full, or full with pop)
//   pop            : dequeue the head
//   full, empty    : occupancy flags
//   head           : ID at the read pointer
module axis_rp_id_fifo #(
    parameter int unsigned ID_W  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]  wr_ptr, rd_ptr;
    logic [ID_W-1:0] mem [DEPTH];
    logic            wr_en, rd_en;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        wr_en = push && (!full || pop);
        rd_en = pop && !empty;
        head  = mem[rd_ptr[PTR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= push_id;
    end

endmodule

// File: rtl/axis_rp_arbiter.sv
// Packet-granular round-robin arbiter sharing one partition stream ingress
// among NUM_REQ requesters, with return packets routed back to the requester
// whose forward packet they answer.
//   clk50mhz_0, peripheral_aresetn_0 : clock, async active-low reset
//   bus      : stream bundle (axis_rp_arbiter_if.master)
//   grant_id : current or last granted requester
//   busy     : forward packet in progress
//   pkt_cnt  : per-requester saturating forward packet counters, present only
//              when AXIS_RP_ARB_PKT_CNT_EN is defined
module axis_rp_arbiter
    import axis_rp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ID_DEPTH = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk50mhz_0,
    input  logic                   peripheral_aresetn_0,
    axis_rp_arbiter_if.master      bus,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
`ifdef AXIS_RP_ARB_PKT_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]  pkt_cnt
`endif
);
    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] head;
    logic            fifo_full, fifo_empty;
    logic            grant_req, fwd_last, ret_last;

    always_comb begin
        pick      = ID_W'(rr_pick(8'(bus.s_tvalid), 3'(rr_ptr), NUM_REQ));
        grant_req = (state == IDLE) && (|bus.s_tvalid) && !fifo_full;
    end

    // Forward path: straight mux of the granted lane, no added latency.
    always_comb begin
        bus.m_tdata  = bus.s_tdata[32'(grant_id) * DATA_W +: DATA_W];
        bus.m_tlast  = bus.s_tlast[grant_id];
        bus.m_tvalid = (state == BUSY) && bus.s_tvalid[grant_id];
        bus.s_tready = '0;
        if (state == BUSY) bus.s_tready[grant_id] = bus.m_tready;
        fwd_last     = bus.m_tvalid && bus.m_tready && bus.m_tlast;
    end

    // Return path: steered by the oldest outstanding grant.
    always_comb begin
        bus.o_tdata  = bus.r_tdata;
        bus.o_tlast  = bus.r_tlast;
        bus.o_tvalid = '0;
        bus.r_tready = 1'b0;
        if (!fifo_empty) begin
            bus.o_tvalid[head] = bus.r_tvalid;
            bus.r_tready       = bus.o_tready[head];
        end
        ret_last = bus.r_tvalid && bus.r_tready && bus.r_tlast;
    end

    always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
        if (!peripheral_aresetn_0) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_req) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (fwd_last) begin
                        rr_ptr <= grant_id;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_rp_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (ID_DEPTH)
    ) u_id_fifo (
        .clk     (clk50mhz_0),
        .rst_n   (peripheral_aresetn_0),
        .push    (grant_req),
        .push_id (pick),
        .pop     (ret_last),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

`ifdef AXIS_RP_ARB_PKT_CNT_EN
    logic [31:0] cnt [NUM_REQ];

    always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
        if (!peripheral_aresetn_0) begin
            for (int i = 0; i < int'(NUM_REQ); i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (fwd_last && grant_id == ID_W'(i) && cnt[i] != 32'hFFFF_FFFF) begin
                    cnt[i] <= cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) pkt_cnt[i*32 +: 32] = cnt[i];
    end
`endif

endmodule

// File: doc/axis_rp_arbiter.md
Name: axis_rp_arbiter

Overview:
- Shares the single AXI-Stream ingress of a reconfigurable partition (512-bit TXD/RXD pair) among NUM_REQ requesters.
- Packet-granular round-robin arbitration on the forward path.
- Return packets from the partition go back to the requester that issued the matching forward packet, tracked by an in-order grant-ID FIFO.
- Sits in the static region between the requester streams and the partition's AXI_STR_TXD_0 / AXI_STR_RXD_0 ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 512, stream data width.
- ID_DEPTH, 4, outstanding-packet FIFO depth (power of two, at least 2).

Ports:
- clk50mhz_0  in  1  sole clock.
- peripheral_aresetn_0  in  1  asynchronous active-low reset.
- s_tdata  in  NUM_REQ*DATA_W  requester forward data; slice i belongs to requester i.
- s_tlast  in  NUM_REQ  per-requester last.
- s_tvalid  in  NUM_REQ  per-requester valid.
- s_tready  out  NUM_REQ  per-requester ready.
- m_tdata  out  DATA_W  to partition TXD.
- m_tlast  out  1  to partition TXD.
- m_tvalid  out  1  to partition TXD.
- m_tready  in  1  from partition TXD.
- r_tdata  in  DATA_W  from partition RXD.
- r_tlast  in  1  from partition RXD.
- r_tvalid  in  1  from partition RXD.
- r_tready  out  1  to partition RXD.
- o_tdata  out  DATA_W  return data, broadcast to all requesters.
- o_tlast  out  1  return last, broadcast.
- o_tvalid  out  NUM_REQ  return valid, one-hot to the owning requester.
- o_tready  in  NUM_REQ  per-requester return ready.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  forward packet in progress.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, busy=0.
  - ID FIFO empty.
  - All s_tready=0, m_tvalid=0, r_tready=0, o_tvalid=0.
- FSM IDLE:
  - If any s_tvalid and the FIFO is not full, select the first asserted requester searching from rr_ptr+1 with wrap-around.
  - Register grant_id, push grant_id into the FIFO, set busy=1, go to BUSY.
  - Grant takes effect the cycle after the request is seen (1-cycle arbitration latency).
  - No s_tready is asserted in IDLE.
- FSM BUSY:
  - Combinational pass-through: m_tdata/m_tlast/m_tvalid = s_*[grant_id]; s_tready[grant_id]=m_tready; other s_tready=0.
  - Zero added data latency.
  - On the beat where m_tvalid & m_tready & m_tlast: rr_ptr<=grant_id, busy<=0, go to IDLE.
  - Packets are never interleaved; a granted requester holds the bus until its tlast, including across tvalid gaps.
- Back-to-back packets: at least one IDLE cycle between packets, so peak throughput is (L beats)/(L+1).
- FIFO full: no new grant. The packet in flight completes normally.
- Return path:
  - If the FIFO is empty, r_tready=0 and o_tvalid=0.
  - Otherwise, with head=FIFO head: o_tvalid[head]=r_tvalid, r_tready=o_tready[head], and o_tdata/o_tlast = r_tdata/r_tlast.
  - Pop on r_tvalid & r_tready & r_tlast.
- FIFO counts:
  - Push and pop in the same cycle leave the count unchanged, and are legal even when full.
  - A pop on the same entry being pushed cannot occur when empty, because the push is registered first.
- Return ordering: responses must return in the same order as their forward packets (partition property). A return packet may start before its forward packet finishes.
- Reset mid-packet: forward and return packets are truncated with no tlast emitted. Upstream is reset in the same domain.
- FIFO pointers are $clog2(ID_DEPTH) bits wrapping naturally, plus an extra wrap bit for full/empty detection.

Optional Feature:
- Macro: AXIS_RP_ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt [NUM_REQ*32], one 32-bit saturating counter per requester.
  - A counter increments on each forward tlast handshake of that requester and holds at 32'hFFFFFFFF.
  - Counters reset to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package axis_rp_arb_pkg:
  - state enum {IDLE, BUSY}.
  - DATA_W_DEF=512.
  - Function rr_pick(req, ptr) returning the next index.
- Sub-module axis_rp_id_fifo: sync FIFO of $clog2(NUM_REQ)-bit IDs, depth ID_DEPTH, with push/pop/full/empty/head.

Test Plan:
- Single requester: req2 sends a 3-beat packet with tdata 1,2,3 and m_tready=1 → grant_id=2 one cycle after tvalid; m_tdata 1,2,3 on consecutive cycles; busy drops after beat 3; FIFO holds {2}.
- Fairness: all 4 requesters continuously valid with 1-beat packets → grant order 0,1,2,3,0,1,…; each packet is followed by one IDLE cycle.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat packet from req1 → s_tready[1] mirrors m_tready; no beat is lost or duplicated; other s_tready stay 0.
- Return routing: forward packets from req3 then req0, then two return packets of 2 beats each → first is delivered with o_tvalid=4'b1000, second with 4'b0001; r_tready follows o_tready of the head requester only.
- FIFO full: ID_DEPTH=4, four forward packets with no returns → fifth request is not granted (s_tready=0); after one return tlast pop, the grant follows 1 cycle later.
- Async reset while req0 is mid-packet (beat 2 of 4) → all outputs go to their reset values immediately; after release, FIFO is empty and the first grant goes to req0.
